data_memory_ls: RTL and testbench

- Parametrised, byte-addressable data memory for the RISC-V variant core, replacing the fixed word-only data memory.
- Supports byte, halfword and word loads/stores with sign/zero extension, big-endian byte order and per-lane write enables.
- Misaligned accesses that cross a word boundary are either split into two cycles by a small FSM or flagged as errors.
- Sits between the core's execute/memory stage and the writeback mux.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_lane_align.sv | 85 ++++++++
 rtl/data_memory_ls.sv | 199 +++++++++++++++++++
 tb/tb_data_memory_ls.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory: access sizes,
// split-access FSM states and the byte count of each access size.
package dmem_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_e;

  // Reserved size reports zero bytes so callers can treat it as invalid.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] nb;
    case (size)
      SZ_B:    nb = 3'd1;
      SZ_H:    nb = 3'd2;
      SZ_W:    nb = 3'd4;
      default: nb = 3'd0;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational big-endian lane steering: per-word byte enables, store data
// placement, and load gather/extend across a low word and the following word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        signed_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] rd_lo_i,
  input  logic [31:0] rd_hi_i,
  output logic [3:0]  be_lo_o,
  output logic [3:0]  be_hi_o,
  output logic [31:0] wd_lo_o,
  output logic [31:0] wd_hi_o,
  output logic [31:0] load_o,
  output logic [31:0] echo_o,
  output logic        cross_o,
  output logic        size_ok_o
);

  logic [2:0]  nb_s;
  logic [5:0]  sh_s;
  logic [31:0] wd_msb_s;
  logic [31:0] gath_s;
  logic [31:0] raw_s;

  // Byte j of the access lives at address offset off+j; offsets 4..6 fall
  // into the next word. Lane p of a word occupies bits [8*(3-p) +: 8].
  always_comb begin
    logic [2:0] pos;
    int         lane;
    nb_s      = size_bytes(size_i);
    cross_o   = (({1'b0, off_i} + nb_s) > 3'd4);
    size_ok_o = (nb_s != 3'd0);
    sh_s      = {(3'd4 - nb_s), 3'b000};
    wd_msb_s  = wd_i << sh_s;
    be_lo_o   = 4'b0000;
    be_hi_o   = 4'b0000;
    wd_lo_o   = 32'h0000_0000;
    wd_hi_o   = 32'h0000_0000;
    gath_s    = 32'h0000_0000;
    for (int j = 0; j < 4; j++) begin
      pos  = {1'b0, off_i} + 3'(j);
      lane = int'(pos[1:0]);
      if (3'(j) < nb_s) begin
        if (pos[2]) begin
          be_hi_o[lane]               = 1'b1;
          wd_hi_o[8*(3-lane) +: 8]    = wd_msb_s[8*(3-j) +: 8];
          gath_s[8*(3-j) +: 8]        = rd_hi_i[8*(3-lane) +: 8];
        end else begin
          be_lo_o[lane]               = 1'b1;
          wd_lo_o[8*(3-lane) +: 8]    = wd_msb_s[8*(3-j) +: 8];
          gath_s[8*(3-j) +: 8]        = rd_lo_i[8*(3-lane) +: 8];
        end
      end else begin
        gath_s = gath_s;
      end
    end
    raw_s = gath_s >> sh_s;
  end

  // Sign/zero extension of the gathered load and masking of the store echo.
  always_comb begin
    case (size_i)
      SZ_B: begin
        load_o = (signed_i && raw_s[7])  ? {24'hFF_FFFF, raw_s[7:0]} : {24'h00_0000, raw_s[7:0]};
        echo_o = {24'h00_0000, wd_i[7:0]};
      end
      SZ_H: begin
        load_o = (signed_i && raw_s[15]) ? {16'hFFFF, raw_s[15:0]} : {16'h0000, raw_s[15:0]};
        echo_o = {16'h0000, wd_i[15:0]};
      end
      SZ_W: begin
        load_o = raw_s;
        echo_o = wd_i;
      end
      default: begin
        load_o = 32'h0000_0000;
        echo_o = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_ls.sv
// Byte-addressable big-endian data memory with sub-word loads/stores and an
// optional two-cycle split for accesses that cross a word boundary.
module data_memory_ls
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];

  state_e        state_q;
  logic [31:0]   rd_q;
  logic          valid_q;
  logic          busy_q;
  logic          err_q;
  logic [AW-1:0] nxt_idx_q;
  logic [31:0]   part_q;
  logic [31:0]   wd_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic          signed_q;
  logic          we_q;

  logic [AW-1:0] idx_s;
  logic [AW-1:0] idx_inc_s;
  logic [1:0]    al_size_s;
  logic [1:0]    al_off_s;
  logic          al_sgn_s;
  logic          al_we_s;
  logic [31:0]   al_wd_s;
  logic [31:0]   al_rd_lo_s;
  logic [31:0]   al_rd_hi_s;
  logic [3:0]    be_lo_s;
  logic [3:0]    be_hi_s;
  logic [31:0]   wd_lo_s;
  logic [31:0]   wd_hi_s;
  logic [31:0]   load_s;
  logic [31:0]   echo_s;
  logic [31:0]   res_s;
  logic          cross_s;
  logic          size_ok_s;
  logic          err_req_s;
  logic          split_s;
  logic          wr_en_s;
  logic [AW-1:0] wr_idx_s;
  logic [3:0]    wr_be_s;
  logic [31:0]   wr_data_s;
  logic          unused_s;

  assign idx_s     = a_i[AW+1:2];
  assign idx_inc_s = idx_s + 1'b1;
  assign unused_s  = ^a_i[31:AW+2];

  // During SECOND the aligner works from the latched request and first-word data.
  always_comb begin
    if (state_q == ST_SECOND) begin
      al_size_s  = size_q;
      al_off_s   = off_q;
      al_sgn_s   = signed_q;
      al_we_s    = we_q;
      al_wd_s    = wd_q;
      al_rd_lo_s = part_q;
      al_rd_hi_s = mem_q[nxt_idx_q];
    end else begin
      al_size_s  = size_i;
      al_off_s   = a_i[1:0];
      al_sgn_s   = signed_i;
      al_we_s    = we_i;
      al_wd_s    = wd_i;
      al_rd_lo_s = mem_q[idx_s];
      al_rd_hi_s = mem_q[idx_inc_s];
    end
  end

  dmem_lane_align u_align (
    .size_i    (al_size_s),
    .off_i     (al_off_s),
    .signed_i  (al_sgn_s),
    .wd_i      (al_wd_s),
    .rd_lo_i   (al_rd_lo_s),
    .rd_hi_i   (al_rd_hi_s),
    .be_lo_o   (be_lo_s),
    .be_hi_o   (be_hi_s),
    .wd_lo_o   (wd_lo_s),
    .wd_hi_o   (wd_hi_s),
    .load_o    (load_s),
    .echo_o    (echo_s),
    .cross_o   (cross_s),
    .size_ok_o (size_ok_s)
  );

  assign err_req_s = ~size_ok_s | (cross_s & ~MISALIGN_EN);
  assign split_s   = cross_s & MISALIGN_EN & size_ok_s;
  assign res_s     = al_we_s ? echo_s : load_s;

  // Write port: low-word lanes on acceptance, remaining lanes in SECOND.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = idx_s;
    wr_be_s   = be_lo_s;
    wr_data_s = wd_lo_s;
    if (state_q == ST_SECOND) begin
      wr_en_s   = we_q;
      wr_idx_s  = nxt_idx_q;
      wr_be_s   = be_hi_s;
      wr_data_s = wd_hi_s;
    end else begin
      wr_en_s   = req_i & we_i & ~err_req_s;
    end
  end

  // Storage array, deliberately without reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int p = 0; p < 4; p++) begin
        if (wr_be_s[p]) begin
          mem_q[wr_idx_s][8*(3-p) +: 8] <= wr_data_s[8*(3-p) +: 8];
        end
      end
    end
  end

  // Access FSM and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rd_q      <= 32'h0000_0000;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      nxt_idx_q <= '0;
      part_q    <= 32'h0000_0000;
      wd_q      <= 32'h0000_0000;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      signed_q  <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            if (err_req_s) begin
              valid_q <= 1'b1;
              err_q   <= 1'b1;
              rd_q    <= 32'h0000_0000;
            end else if (split_s) begin
              state_q   <= ST_SECOND;
              busy_q    <= 1'b1;
              nxt_idx_q <= idx_inc_s;
              part_q    <= al_rd_lo_s;
              wd_q      <= wd_i;
              size_q    <= size_i;
              off_q     <= a_i[1:0];
              signed_q  <= signed_i;
              we_q      <= we_i;
            end else begin
              valid_q <= 1'b1;
              rd_q    <= res_s;
            end
          end
        end
        ST_SECOND: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          rd_q    <= res_s;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_o    = rd_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_data_memory_ls.sv
// Directed scoreboard bench for data_memory_ls: three instances cover split
// accesses, a 4-word wrapping memory and the reject-misaligned configuration.
module tb_data_memory_ls;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sgn = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] wd = 32'h0;
  logic [31:0] rd [3];
  logic [2:0]  valid;
  logic [2:0]  busy;
  logic [2:0]  err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_rd_q [$];
  logic        exp_err_q [$];
  string       tag_q [$];

  always #5 clk = ~clk;

  data_memory_ls #(.DEPTH_WORDS(1024), .MISALIGN_EN(1'b1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we), .size_i(size), .signed_i(sgn),
    .a_i(a), .wd_i(wd), .rd_o(rd[0]), .valid_o(valid[0]), .busy_o(busy[0]), .err_o(err[0]));

  data_memory_ls #(.DEPTH_WORDS(4), .MISALIGN_EN(1'b1)) u_w (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we), .size_i(size), .signed_i(sgn),
    .a_i(a), .wd_i(wd), .rd_o(rd[1]), .valid_o(valid[1]), .busy_o(busy[1]), .err_o(err[1]));

  data_memory_ls #(.DEPTH_WORDS(1024), .MISALIGN_EN(1'b0)) u_e (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .we_i(we), .size_i(size), .signed_i(sgn),
    .a_i(a), .wd_i(wd), .rd_o(rd[2]), .valid_o(valid[2]), .busy_o(busy[2]), .err_o(err[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] e_rd, input logic e_err, input string tag);
    exp_rd_q.push_back(e_rd);
    exp_err_q.push_back(e_err);
    tag_q.push_back(tag);
  endtask

  task automatic collect(input int inst);
    string tag;
    if (tag_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      tag = tag_q.pop_front();
      check({tag, ":valid"}, 32'(valid[inst]), 32'd1);
      check({tag, ":rd"}, rd[inst], exp_rd_q.pop_front());
      check({tag, ":err"}, 32'(err[inst]), 32'(exp_err_q.pop_front()));
    end
  endtask

  // Called #1 after a rising edge; lat is the expected edges from REQ to VALID.
  task automatic access(input int inst, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] e_rd, input logic e_err, input int lat,
                        input string tag);
    int cyc;
    we = w; size = sz; sgn = sg; a = addr; wd = data;
    req[inst] = 1'b1;
    push_exp(e_rd, e_err, tag);
    @(posedge clk); #1;
    req[inst] = 1'b0;
    check({tag, ":busy"}, 32'(busy[inst]), (lat == 2) ? 32'd1 : 32'd0);
    cyc = 1;
    while (valid[inst] !== 1'b1 && cyc < 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ":latency"}, 32'(cyc), 32'(lat));
    collect(inst);
    @(posedge clk); #1;
    check({tag, ":pulse"}, {29'd0, busy[inst], valid[inst], err[inst]}, 32'd0);
  endtask

  initial begin
    // Reset state of all instances.
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_rd%0d", i), rd[i], 32'd0);
      check($sformatf("reset_flags%0d", i), {29'd0, valid[i], busy[i], err[i]}, 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned and sub-word accesses.
    access(0, 1'b1, SZ_W, 1'b0, 32'h100, 32'h1122_3344, 32'h1122_3344, 1'b0, 1, "st_w_100");
    access(0, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0,        32'h1122_3344, 1'b0, 1, "ld_w_100");
    access(0, 1'b0, SZ_B, 1'b0, 32'h101, 32'h0,        32'h0000_0022, 1'b0, 1, "ld_bu_101");
    access(0, 1'b1, SZ_B, 1'b0, 32'h102, 32'hABCD_EFF0, 32'h0000_00F0, 1'b0, 1, "st_b_102");
    access(0, 1'b0, SZ_H, 1'b1, 32'h102, 32'h0,        32'hFFFF_F044, 1'b0, 1, "ld_hs_102");
    access(0, 1'b0, SZ_H, 1'b0, 32'h102, 32'h0,        32'h0000_F044, 1'b0, 1, "ld_hu_102");

    // Split accesses across the 0x100/0x104 word boundary.
    access(0, 1'b1, SZ_W, 1'b0, 32'h103, 32'hAABB_CCDD, 32'hAABB_CCDD, 1'b0, 2, "st_w_103");
    access(0, 1'b0, SZ_W, 1'b0, 32'h103, 32'h0,        32'hAABB_CCDD, 1'b0, 2, "ld_w_103");
    access(0, 1'b0, SZ_B, 1'b0, 32'h104, 32'h0,        32'h0000_00BB, 1'b0, 1, "ld_bu_104");
    access(0, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0,        32'h1122_F0AA, 1'b0, 1, "ld_w_100b");
    access(0, 1'b0, SZ_B, 1'b1, 32'h103, 32'h0,        32'hFFFF_FFAA, 1'b0, 1, "ld_bs_103");
    access(0, 1'b0, SZ_H, 1'b1, 32'h103, 32'h0,        32'hFFFF_AABB, 1'b0, 2, "ld_hs_103");
    access(0, 1'b1, SZ_H, 1'b0, 32'h200, 32'hDEAD_8765, 32'h0000_8765, 1'b0, 1, "st_h_200");
    access(0, 1'b0, SZ_H, 1'b1, 32'h200, 32'h0,        32'hFFFF_8765, 1'b0, 1, "ld_hs_200");
    access(0, 1'b0, SZ_H, 1'b0, 32'h1200, 32'h0,       32'h0000_8765, 1'b0, 1, "ld_alias_1200");
    access(0, 1'b1, SZ_RSV, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, "rsv_en");
    access(0, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0,        32'h1122_F0AA, 1'b0, 1, "ld_after_rsv");

    // Back-to-back aligned loads with REQ held high.
    we = 1'b0; size = SZ_W; sgn = 1'b0; a = 32'h100; req[0] = 1'b1;
    push_exp(32'h1122_F0AA, 1'b0, "b2b_0");
    @(posedge clk); #1;
    size = SZ_B; a = 32'h101;
    push_exp(32'h0000_0022, 1'b0, "b2b_1");
    collect(0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    collect(0);
    @(posedge clk); #1;

    // Wrap from the last word to word 0 in a 4-word memory.
    access(1, 1'b1, SZ_H, 1'b0, 32'h0F, 32'h0000_1234, 32'h0000_1234, 1'b0, 2, "wrap_st_h");
    access(1, 1'b0, SZ_B, 1'b0, 32'h0F, 32'h0,        32'h0000_0012, 1'b0, 1, "wrap_ld_b0f");
    access(1, 1'b0, SZ_B, 1'b0, 32'h00, 32'h0,        32'h0000_0034, 1'b0, 1, "wrap_ld_b00");
    access(1, 1'b0, SZ_H, 1'b0, 32'h0F, 32'h0,        32'h0000_1234, 1'b0, 2, "wrap_ld_h");
    access(1, 1'b0, SZ_B, 1'b0, 32'h10, 32'h0,        32'h0000_0034, 1'b0, 1, "wrap_alias");

    // Reject configuration.
    access(2, 1'b1, SZ_W, 1'b0, 32'h100, 32'h0102_0304, 32'h0102_0304, 1'b0, 1, "rej_st_w");
    access(2, 1'b1, SZ_W, 1'b0, 32'h101, 32'hFFFF_FFFF, 32'h0,        1'b1, 1, "rej_st_cross");
    access(2, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0,        32'h0102_0304, 1'b0, 1, "rej_unchanged");
    access(2, 1'b0, SZ_H, 1'b0, 32'h103, 32'h0,        32'h0,        1'b1, 1, "rej_ld_h_cross");
    access(2, 1'b0, SZ_RSV, 1'b0, 32'h100, 32'h0,      32'h0,        1'b1, 1, "rej_rsv");
    access(2, 1'b0, SZ_H, 1'b0, 32'h102, 32'h0,        32'h0000_0304, 1'b0, 1, "rej_ld_h_ok");

    // Reset during the first cycle of a split access.
    we = 1'b0; size = SZ_W; sgn = 1'b0; a = 32'h103; req[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    check("mid_split_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_rd", rd[0], 32'd0);
    check("mid_reset_flags", {29'd0, valid[0], busy[0], err[0]}, 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("no_stale_valid%0d", i), {29'd0, valid[0], busy[0], err[0]}, 32'd0);
    end
    access(0, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h1122_F0AA, 1'b0, 1, "post_reset_ld");

    check("scoreboard_drained", 32'(tag_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
